// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO registers; mult/div results land MULT_CYCLES/DIV_CYCLES cycles after start.
// Latency: busy for N cycles, then done pulses with HI/LO updated; mthi/mtlo write on the start edge.
// Backpressure: start is ignored while busy; the decoder stalls dependent instructions on busy.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} stateT;

    typedef struct packed {
        logic             we;
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
    } holdT;

    stateT            state, stateNext;
    logic [CNT_W-1:0] cnt, cntLoad;
    holdT             hold, holdNext;
    logic             accept, finish;

    logic [2*WIDTH-1:0] prodS, prodU;
    logic [WIDTH-1:0]   divisorU, absA, absB, magQ, magR, quotS, remS, quotU, remU;
    logic               negA, negB;

    // Signed divide runs on magnitudes so the most-negative / -1 case never
    // reaches a signed divider; it wraps to quotient = srcA, remainder = 0.
    always_comb begin
        prodS    = {{WIDTH{srcA[WIDTH-1]}}, srcA} * {{WIDTH{srcB[WIDTH-1]}}, srcB};
        prodU    = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};
        negA     = srcA[WIDTH-1];
        negB     = srcB[WIDTH-1];
        absA     = negA ? (~srcA + WIDTH'(1)) : srcA;
        absB     = negB ? (~srcB + WIDTH'(1)) : srcB;
        if (srcB == '0) begin
            absB = WIDTH'(1);
        end
        divisorU = (srcB == '0) ? WIDTH'(1) : srcB;
        magQ     = absA / absB;
        magR     = absA % absB;
        quotS    = (negA ^ negB) ? (~magQ + WIDTH'(1)) : magQ;
        remS     = negA ? (~magR + WIDTH'(1)) : magR;
        quotU    = srcA / divisorU;
        remU     = srcA % divisorU;
    end

    always_comb begin
        holdNext = '0;
        cntLoad  = CNT_W'(MULT_CYCLES);
        accept   = 1'b0;
        if (state == IDLE && start) begin
            case (op)
                OP_MULT: begin
                    holdNext = '{we: 1'b1, hi: prodS[2*WIDTH-1:WIDTH], lo: prodS[WIDTH-1:0]};
                    accept   = 1'b1;
                end
                OP_MULTU: begin
                    holdNext = '{we: 1'b1, hi: prodU[2*WIDTH-1:WIDTH], lo: prodU[WIDTH-1:0]};
                    accept   = 1'b1;
                end
                OP_DIV: begin
                    holdNext = '{we: (srcB != '0), hi: remS, lo: quotS};
                    cntLoad  = CNT_W'(DIV_CYCLES);
                    accept   = 1'b1;
                end
                OP_DIVU: begin
                    holdNext = '{we: (srcB != '0), hi: remU, lo: quotU};
                    cntLoad  = CNT_W'(DIV_CYCLES);
                    accept   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        finish    = 1'b0;
        case (state)
            IDLE: if (accept) stateNext = RUN;
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    finish    = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= stateNext;
            done  <= finish;
            if (accept) begin
                hold <= holdNext;
                cnt  <= cntLoad;
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (finish) begin
                if (hold.we) begin
                    hi <= hold.hi;
                    lo <= hold.lo;
                end
            end else if (state == IDLE && start) begin
                if (op == OP_MTHI) hi <= srcA;
                if (op == OP_MTLO) lo <= srcA;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: vector table for single ops plus hand-written multi-cycle sequences.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA, srcB;
    logic        busy, done;
    logic [31:0] hi, lo;

    int nTests = 0;
    int nFail  = 0;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          cyc;
    } vecT;

    vecT vec[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single cycle, then scrambles operands to show they are not re-read.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        step();
        start = 1'b0;
        op    = 3'd0;
        srcA  = 32'hDEAD_BEEF;
        srcB  = 32'h0BAD_F00D;
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        logic seenDone;

        vec[0]  = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vec[1]  = '{3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 5};
        vec[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vec[3]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vec[4]  = '{3'd5, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'h8000_0000, 0};
        vec[5]  = '{3'd6, 32'h0000_5678, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 0};
        vec[6]  = '{3'd4, 32'h0000_0007, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 10};
        vec[7]  = '{3'd4, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10};
        vec[8]  = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vec[9]  = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vec[10] = '{3'd3, 32'hFFFF_FFF8, 32'h0000_0000, 32'h3FFF_FFFF, 32'h0000_0001, 10};
        vec[11] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vec[12] = '{3'd7, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFE, 32'h0000_0001, 0};
        vec[13] = '{3'd0, 32'h3333_3333, 32'h4444_4444, 32'hFFFF_FFFE, 32'h0000_0001, 0};

        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        srcA  = '0;
        srcB  = '0;
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("reset hi c%0d", c), 64'(hi), 64'h0);
            check($sformatf("reset lo c%0d", c), 64'(lo), 64'h0);
            check($sformatf("reset busy c%0d", c), 64'(busy), 64'h0);
            check($sformatf("reset done c%0d", c), 64'(done), 64'h0);
            step();
        end

        for (int i = 0; i < 14; i++) begin
            issue(vec[i].op, vec[i].a, vec[i].b);
            if (vec[i].cyc > 0) begin
                countBusy(n);
                check($sformatf("v%0d busy cycles", i), 64'(n), 64'(vec[i].cyc));
                check($sformatf("v%0d done", i), 64'(done), 64'h1);
            end else begin
                check($sformatf("v%0d busy", i), 64'(busy), 64'h0);
                check($sformatf("v%0d done", i), 64'(done), 64'h0);
            end
            check($sformatf("v%0d hi", i), 64'(hi), 64'(vec[i].expHi));
            check($sformatf("v%0d lo", i), 64'(lo), 64'(vec[i].expLo));
            step();
            check($sformatf("v%0d done after", i), 64'(done), 64'h0);
        end

        // Starts while busy (mthi, multu) must be dropped.
        issue(3'd2, 32'h0000_0003, 32'h0000_0005);
        step();
        start = 1'b1; op = 3'd5; srcA = 32'h0000_AAAA;
        step();
        op = 3'd2; srcA = 32'hFFFF_FFFF; srcB = 32'hFFFF_FFFF;
        step();
        start = 1'b0; op = 3'd0;
        countBusy(n);
        check("busy-ignore cycles", 64'(n), 64'd2);
        check("busy-ignore done", 64'(done), 64'h1);
        check("busy-ignore hi", 64'(hi), 64'h0);
        check("busy-ignore lo", 64'(lo), 64'hF);
        step();
        check("busy-ignore no rerun", 64'(busy), 64'h0);

        // New mult accepted in the done cycle.
        issue(3'd1, 32'h0000_0002, 32'h0000_0003);
        countBusy(n);
        check("b2b first done", 64'(done), 64'h1);
        check("b2b first lo", 64'(lo), 64'h6);
        issue(3'd1, 32'h0000_0004, 32'h0000_0005);
        check("b2b busy rises", 64'(busy), 64'h1);
        check("b2b done cleared", 64'(done), 64'h0);
        countBusy(n);
        check("b2b second cycles", 64'(n), 64'd5);
        check("b2b second lo", 64'(lo), 64'd20);
        step();

        // Reset in cycle T+3 of a divide.
        issue(3'd4, 32'h0000_0064, 32'h0000_0007);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset busy", 64'(busy), 64'h0);
        check("midreset hi", 64'(hi), 64'h0);
        check("midreset lo", 64'(lo), 64'h0);
        seenDone = 1'b0;
        for (int c = 0; c < 15; c++) begin
            seenDone = seenDone | done | busy;
            step();
        end
        check("midreset no done/busy later", 64'(seenDone), 64'h0);
        check("midreset lo held", 64'(lo), 64'h0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
